life_gen_scheduler: RTL and testbench
=====================================

Name: life_gen_scheduler

Overview:
- Sequences one Game of Life generation at a time for the 210x160 cell grid shown on the VGA display.
- Issues row-compute requests (rows 0..159) to the row-update engine over a req/ack handshake.
- Waits for vertical blanking, then pulses a buffer swap so the display path always reads a complete, stable grid.
- Paces generations in frames, with run/pause and single-step control.

Parameters:
- GRID_ROWS, 160, number of cell rows (Y).
- ROW_W, 8, width of row_idx.
- DIV_W, 4, width of frame divider and frame counter.

Ports:
- clk  input  1  system clock.
- rst  input  1  synchronous, active-high reset.
- vblank  input  1  high during vertical blanking, synchronous to clk.
- run  input  1  level; free-running generations when high.
- step  input  1  one-cycle pulse; request exactly one generation.
- frame_div  input  DIV_W  minimum number of frames between generations.
- row_req  output  1  row compute request.
- row_idx  output  ROW_W  row being requested.
- row_ack  input  1  engine has finished the row at row_idx.
- swap  output  1  one-cycle pulse; flip front/back grid buffers.
- busy  output  1  high whenever state != IDLE.
- gen_count  output  16  generations completed (see optional feature).

Behaviour:
- Reset:
  - state=IDLE; row_req=0, row_idx=0, swap=0, busy=0, gen_count=0.
  - Frame counter=0, step_pending=0, vblank_q=0.
  - rst wins over every other input in the same cycle.
- Edge detect: vb_rise = vblank & ~vblank_q; vblank_q is registered every cycle.
- Frame counter: increments on each vb_rise, saturating at 2^DIV_W-1. Cleared in the cycle a generation starts.
- step_pending: set on step; cleared when a generation starts. A step arriving while busy is held and starts the next generation.
- Start condition: IDLE and ((run and frame_cnt >= frame_div) or step_pending). frame_div=0 lets a new generation start the cycle after the previous one ends.
- States:
  - IDLE:
    - On the start condition -> COMPUTE; row_idx=0 and row_req=1 from the next cycle (1-cycle latency).
  - COMPUTE:
    - row_req held high and row_idx stable until row_ack is sampled high.
    - On ack with row_idx < GRID_ROWS-1: row_idx increments next cycle and row_req stays high. Back-to-back acks give one row per cycle.
    - On ack with row_idx == GRID_ROWS-1: row_req=0 next cycle -> WAIT_VB.
  - WAIT_VB:
    - row_req=0. Only a vb_rise sampled in this state advances -> SWAP.
    - A rise in the same cycle as entry is not counted.
  - SWAP:
    - swap=1 for exactly one cycle; gen_count increments (wraps at 65535->0) -> IDLE.
- row_ack is ignored when row_req=0.
- run falling mid-generation: the current generation completes and swaps; no new one starts.
- Compute longer than one frame: the swap occurs at the first vblank rise after the last ack.
- rst mid-generation: the generation is abandoned, row_req drops and no swap occurs.

Optional Feature:
- Macro LIFE_GEN_COUNT_EN.
- Defined: 16-bit gen_count register as described.
- Undefined: no counter register; gen_count is tied to 0.

Decomposition:
- Package life_pkg:
  - GRID_COLS=210, GRID_ROWS=160, CELL_PIX=3, X_OFFSET=5.
  - State enum {IDLE, COMPUTE, WAIT_VB, SWAP}.
- Sub-module rise_det: registered rising-edge detector, instantiated for vblank.

Test Plan:
- Reset: rst high 3 cycles with run=1, vblank toggling -> all outputs 0, state IDLE, no row_req.
- Step: run=0, frame_div=0, step pulse, engine acks 1 cycle after each req.
  - row_idx sequences 0..159, one row per 2 cycles.
  - swap pulses exactly once, on the cycle after the next vb_rise.
  - gen_count=1 (with LIFE_GEN_COUNT_EN).
- Free run, frame_div=3: run=1 for 12 vblank rises, fast engine -> exactly 3 swaps, each followed by a start at frame_cnt>=3.
- Slow engine: ack 500 cycles after each req -> req/idx stay stable until ack; a vb_rise during COMPUTE causes no swap; swap follows the first rise after the row-159 ack.
- Mid-operation events:
  - Assert rst at row_idx=80 -> row_req=0 next cycle, no swap, gen_count unchanged.
  - Drop run at row_idx=80 -> generation finishes, 1 swap, then idle.
- Step while busy at row_idx=40 -> second generation starts the cycle after the first swap; spurious row_ack while in IDLE is ignored.

Source files
------------

// File: rtl/life_gen_scheduler_pkg.sv
// ============================================================================
// Module      : life_pkg
// Description : Grid geometry and scheduler state encoding shared by the
//               Game of Life generation scheduler.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

package life_pkg;

   localparam int GRID_COLS = 210;
   localparam int GRID_ROWS = 160;
   localparam int CELL_PIX  = 3;
   localparam int X_OFFSET  = 5;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      COMPUTE = 2'd1,
      WAIT_VB = 2'd2,
      SWAP    = 2'd3
   } state_t;

endpackage

`default_nettype wire

// File: rtl/life_gen_scheduler_if.sv
// ============================================================================
// Module      : life_gen_scheduler_if
// Description : Row-compute request/acknowledge channel between the scheduler
//               (master) and the row-update engine (slave).
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

interface life_gen_scheduler_if #(
   parameter int ROW_W = 8
) ();

   logic             row_req;
   logic [ROW_W-1:0] row_idx;
   logic             row_ack;

   modport master (
      output row_req,
      output row_idx,
      input  row_ack
   );

   modport slave (
      input  row_req,
      input  row_idx,
      output row_ack
   );

endinterface

`default_nettype wire

// File: rtl/life_gen_scheduler_rise_det.sv
// ============================================================================
// Module      : rise_det
// Description : Registered rising-edge detector; o_rise is high in the first
//               cycle i_sig is seen high after being low.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module rise_det (
   input  logic clk,
   input  logic rst,
   input  logic i_sig,
   output logic o_rise
);

   logic r_sig_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_sig_q <= 1'b0;
      end else begin
         r_sig_q <= i_sig;
      end
   end

   assign o_rise = i_sig & ~r_sig_q;

endmodule

`default_nettype wire

// File: rtl/life_gen_scheduler.sv
// ============================================================================
// Module      : life_gen_scheduler
// Description : Sequences one Game of Life generation: requests rows
//               0..GRID_ROWS-1, waits for a vblank rise, then pulses swap.
//               Optional macro LIFE_GEN_COUNT_EN adds the gen_count register.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module life_gen_scheduler
   import life_pkg::*;
#(
   parameter int GRID_ROWS = life_pkg::GRID_ROWS,
   parameter int ROW_W     = 8,
   parameter int DIV_W     = 4
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 vblank,
   input  logic                 run,
   input  logic                 step,
   input  logic [DIV_W-1:0]     frame_div,
   life_gen_scheduler_if.master row_if,
   output logic                 swap,
   output logic                 busy,
   output logic [15:0]          gen_count
);

   localparam logic [DIV_W-1:0] c_FRAME_MAX = '1;
   localparam logic [ROW_W-1:0] c_LAST_ROW  = ROW_W'(GRID_ROWS - 1);

   state_t           r_state;
   state_t           w_state_nxt;
   logic             w_vb_rise;
   logic             w_start;
   logic             w_last_row;
   logic [DIV_W-1:0] r_frame_cnt;
   logic             r_step_pending;
   logic [ROW_W-1:0] r_row_idx;

   rise_det u_vb_rise (
      .clk    (clk),
      .rst    (rst),
      .i_sig  (vblank),
      .o_rise (w_vb_rise)
   );

   assign w_start    = (r_state == IDLE) &&
                       ((run && (r_frame_cnt >= frame_div)) || r_step_pending);
   assign w_last_row = (r_row_idx == c_LAST_ROW);

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         IDLE:    if (w_start) w_state_nxt = COMPUTE;
         COMPUTE: if (row_if.row_ack && w_last_row) w_state_nxt = WAIT_VB;
         WAIT_VB: if (w_vb_rise) w_state_nxt = SWAP;
         SWAP:    w_state_nxt = IDLE;
         default: w_state_nxt = IDLE;
      endcase
   end

   // Row index only moves on an ack that the engine gives while requested.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_row_idx <= '0;
      end else if (w_start) begin
         r_row_idx <= '0;
      end else if ((r_state == COMPUTE) && row_if.row_ack && !w_last_row) begin
         r_row_idx <= r_row_idx + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_frame_cnt <= '0;
      end else if (w_start) begin
         r_frame_cnt <= '0;
      end else if (w_vb_rise && (r_frame_cnt != c_FRAME_MAX)) begin
         r_frame_cnt <= r_frame_cnt + 1'b1;
      end
   end

   // A step coinciding with a start is kept so it is not lost.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_step_pending <= 1'b0;
      end else if (w_start) begin
         r_step_pending <= step;
      end else if (step) begin
         r_step_pending <= 1'b1;
      end
   end

   assign row_if.row_req = (r_state == COMPUTE);
   assign row_if.row_idx = r_row_idx;
   assign swap           = (r_state == SWAP);
   assign busy           = (r_state != IDLE);

`ifdef LIFE_GEN_COUNT_EN
   logic [15:0] r_gen_count;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_gen_count <= '0;
      end else if (r_state == SWAP) begin
         r_gen_count <= r_gen_count + 16'd1;
      end
   end

   assign gen_count = r_gen_count;
`else
   assign gen_count = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_life_gen_scheduler.sv
// ============================================================================
// Module      : tb_life_gen_scheduler
// Description : Self-checking bench for life_gen_scheduler with an
//               engine model, a vblank generator and a reference model.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_life_gen_scheduler;
   import life_pkg::*;

   localparam int ROW_W = 8;
   localparam int DIV_W = 4;
   localparam int FMAX  = (1 << DIV_W) - 1;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             vblank = 1'b0;
   logic             run = 1'b0;
   logic             step = 1'b0;
   logic             ack = 1'b0;
   logic [DIV_W-1:0] frame_div = '0;
   logic             swap;
   logic             busy;
   logic [15:0]      gen_count;

   always #5 clk = ~clk;

   life_gen_scheduler_if #(.ROW_W(ROW_W)) row_if ();
   assign row_if.row_ack = ack;

   life_gen_scheduler #(
      .GRID_ROWS (GRID_ROWS),
      .ROW_W     (ROW_W),
      .DIV_W     (DIV_W)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .vblank    (vblank),
      .run       (run),
      .step      (step),
      .frame_div (frame_div),
      .row_if    (row_if),
      .swap      (swap),
      .busy      (busy),
      .gen_count (gen_count)
   );

   int n_cmp  = 0;
   int n_fail = 0;

   // stimulus environment
   int vb_per = 400, vb_hi = 20, vb_cnt = 0;
   bit vb_last = 0, applied_rise = 0;
   int rises = 0, swaps = 0, req_hi = 0;
   int ack_dly = 1, e_wait = 0;
   bit spur_en = 0;

   // reference model: generation progress expressed as counters and flags
   bit m_on, m_rows_done, m_swap, m_pend, m_vbq;
   int m_row, m_frames, m_gens;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic model_step();
      bit rise, idle, start;
      if (rst) begin
         m_on = 0; m_rows_done = 0; m_swap = 0; m_pend = 0; m_vbq = 0;
         m_row = 0; m_frames = 0; m_gens = 0;
         return;
      end
      rise  = vblank && !m_vbq;
      m_vbq = vblank;
      idle  = !m_on && !m_swap;
      start = idle && ((run && (m_frames >= int'(frame_div))) || m_pend);
      if (m_swap) begin
         m_swap = 0;
         m_gens = (m_gens + 1) % 65536;
      end else if (m_on && !m_rows_done) begin
         if (ack) begin
            if (m_row == GRID_ROWS - 1) m_rows_done = 1;
            else m_row++;
         end
      end else if (m_on && rise) begin
         m_on = 0; m_rows_done = 0; m_swap = 1;
      end
      if (start) begin
         m_on = 1; m_row = 0; m_frames = 0; m_pend = step;
      end else begin
         if (rise && m_frames < FMAX) m_frames++;
         if (step) m_pend = 1;
      end
   endtask

   function automatic int exp_gens();
`ifdef LIFE_GEN_COUNT_EN
      return m_gens;
`else
      return 0;
`endif
   endfunction

   task automatic compare();
      check("row_req", row_if.row_req, m_on && !m_rows_done);
      if (m_on && !m_rows_done) check("row_idx", row_if.row_idx, m_row);
      check("swap", swap, m_swap);
      check("busy", busy, m_on || m_swap);
      check("gen_count", gen_count, exp_gens());
      if (swap === 1'b1) swaps++;
      if (row_if.row_req === 1'b1) req_hi++;
   endtask

   task automatic cycle();
      vblank       = (vb_cnt % vb_per) >= (vb_per - vb_hi);
      applied_rise = vblank && !vb_last;
      if (applied_rise) rises++;
      vb_last = vblank;
      vb_cnt++;
      if (row_if.row_req === 1'b1) begin
         if (e_wait >= ack_dly) begin ack = 1'b1; e_wait = 0; end
         else begin ack = 1'b0; e_wait++; end
      end else begin
         ack    = spur_en ? 1'($urandom_range(0, 1)) : 1'b0;
         e_wait = 0;
      end
      @(posedge clk);
      #1;
      model_step();
      compare();
      step = 1'b0;
   endtask

   task automatic do_reset(input int n);
      vb_cnt = 0; vb_last = 0; e_wait = 0;
      rst = 1'b1;
      repeat (n) cycle();
      rst = 1'b0;
      rises = 0; swaps = 0; req_hi = 0;
   endtask

   task automatic run_until_idx(input int idx, input int budget, input string nm);
      int n = 0;
      while (!(row_if.row_req === 1'b1 && int'(row_if.row_idx) == idx) && n < budget) begin
         cycle();
         n++;
      end
      check(nm, (row_if.row_req === 1'b1) && (int'(row_if.row_idx) == idx), 1);
   endtask

   task automatic wait_swap(input int budget, input string nm);
      int n = 0;
      while (swap !== 1'b1 && n < budget) begin
         cycle();
         n++;
      end
      check(nm, swap, 1);
      check({nm, "_after_rise"}, applied_rise, 1);
   endtask

   typedef struct {
      bit run;
      int div;
      int dly;
      int n_rises;
      int exp_swaps;
   } vec_t;

   vec_t tbl[6];

   initial begin
      tbl[0] = '{1, 3,  1, 12, 3};
      tbl[1] = '{1, 0,  1,  6, 6};
      tbl[2] = '{1, 15, 1, 17, 1};
      tbl[3] = '{0, 0,  1,  5, 0};
      tbl[4] = '{1, 1,  1,  6, 5};
      tbl[5] = '{1, 0,  3,  6, 3};

      // reset with run high and vblank toggling
      run = 1'b1; vb_per = 2; vb_hi = 1;
      rst = 1'b1;
      repeat (3) cycle();
      check("rst_row_req", row_if.row_req, 0);
      check("rst_row_idx", row_if.row_idx, 0);
      check("rst_busy", busy, 0);
      check("rst_swap", swap, 0);
      check("rst_gen_count", gen_count, 0);
      vb_per = 400; vb_hi = 20;

      // single step, engine acks one cycle after each request
      run = 1'b0; frame_div = '0; ack_dly = 1;
      do_reset(2);
      step = 1'b1;
      wait_swap(2000, "step_swap");
      check("step_req_cycles", req_hi, 2 * GRID_ROWS);
      repeat (20) cycle();
      check("step_swap_count", swaps, 1);
      check("step_gen_count", gen_count, exp_gens());
`ifdef LIFE_GEN_COUNT_EN
      check("step_gen_is_one", gen_count, 1);
`endif

      for (int i = 0; i < 6; i++) begin
         int guard;
         run = tbl[i].run; frame_div = DIV_W'(tbl[i].div); ack_dly = tbl[i].dly;
         do_reset(2);
         guard = 0;
         while (rises < tbl[i].n_rises && guard < 20000) begin
            cycle();
            guard++;
         end
         repeat (5) cycle();
         check($sformatf("tbl%0d_rises", i), rises, tbl[i].n_rises);
         check($sformatf("tbl%0d_swaps", i), swaps, tbl[i].exp_swaps);
      end

      // slow engine on first and last rows; vblank rises land mid-compute
      run = 1'b0; frame_div = '0;
      do_reset(2);
      step = 1'b1;
      begin
         int n = 0;
         bit seen_req = 0;
         while (!(seen_req && row_if.row_req !== 1'b1) && n < 5000) begin
            ack_dly = (int'(row_if.row_idx) < 2 || int'(row_if.row_idx) == GRID_ROWS - 1) ? 500 : 1;
            cycle();
            if (row_if.row_req === 1'b1) seen_req = 1;
            n++;
         end
         check("slow_rows_done", busy, 1);
         check("slow_rises_during_compute", rises > 0, 1);
         check("slow_no_early_swap", swaps, 0);
      end
      ack_dly = 1;
      wait_swap(1000, "slow_swap");
      repeat (10) cycle();
      check("slow_swap_count", swaps, 1);

      // reset mid-generation
      do_reset(2);
      step = 1'b1;
      run_until_idx(80, 1000, "rst_mid_reached");
      rst = 1'b1;
      cycle();
      rst = 1'b0;
      check("rst_mid_req", row_if.row_req, 0);
      check("rst_mid_busy", busy, 0);
      swaps = 0;
      repeat (1000) cycle();
      check("rst_mid_no_swap", swaps, 0);
      check("rst_mid_gen_count", gen_count, 0);

      // run dropped mid-generation
      run = 1'b1; frame_div = '0;
      do_reset(2);
      run_until_idx(80, 1000, "drop_run_reached");
      run = 1'b0;
      swaps = 0;
      wait_swap(2000, "drop_run_swap");
      repeat (1000) cycle();
      check("drop_run_swaps", swaps, 1);
      check("drop_run_idle", busy, 0);

      // step while busy, spurious acks while idle
      run = 1'b0; spur_en = 1;
      do_reset(2);
      repeat (20) cycle();
      check("spur_idle", busy, 0);
      step = 1'b1;
      run_until_idx(40, 1000, "busy_step_reached");
      step = 1'b1;
      cycle();
      wait_swap(2000, "busy_step_swap1");
      cycle();
      check("busy_step_idle_gap", busy, 0);
      cycle();
      check("busy_step_restart_req", row_if.row_req, 1);
      check("busy_step_restart_idx", row_if.row_idx, 0);
      wait_swap(2000, "busy_step_swap2");
      cycle();
`ifdef LIFE_GEN_COUNT_EN
      check("busy_step_gen_count", gen_count, 2);
`endif

      // randomized traffic against the model
      vb_per = 300; vb_hi = 10;
      do_reset(2);
      for (int i = 0; i < 15000; i++) begin
         if ($urandom_range(0, 199) == 0) run = ~run;
         if ($urandom_range(0, 96) == 0) step = 1'b1;
         if ($urandom_range(0, 499) == 0) frame_div = DIV_W'($urandom_range(0, 3));
         ack_dly = $urandom_range(0, 2);
         rst = ($urandom_range(0, 4999) == 0);
         cycle();
      end
      rst = 1'b0;
      cycle();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
